// File: rtl/me_integer_core.sv
// Integer-pel block-matching motion estimator: a 16x16 template is compared against
// 16 candidate displacements (-2..+1 on each axis) inside a 64x64 search window.
module me_integer_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [11:0] init_pos,
    output logic [15:0] min_sad,
    output logic [3:0]  min_diff,
    output logic        ack,
    input  logic [7:0]  pel_sw,
    input  logic [7:0]  pel_tb,
    output logic [11:0] addr_sw,
    output logic [7:0]  addr_tb
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Handshake: req is a level; ack rises once the result is final and stays
    // high with stable results until req is seen low, which returns to IDLE.

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_init;
    logic [11:0] r_cnt;
    logic        r_a_v;
    logic        r_b_v;
    logic [11:0] r_b_cnt;
    logic [15:0] r_acc;
    logic [15:0] r_best;
    logic [3:0]  r_best_diff;
    logic [15:0] r_min_sad;
    logic [3:0]  r_min_diff;
    logic        r_ack;
    logic [11:0] r_addr_sw;
    logic [7:0]  r_addr_tb;

    logic        w_start;
    logic        w_issue;
    logic [11:0] w_issue_idx;
    logic [11:0] w_pos;
    logic [5:0]  w_addr_w;
    logic [5:0]  w_addr_h;
    logic [7:0]  w_ad;
    logic [15:0] w_sad;
    logic        w_better;
    logic [3:0]  w_cand_diff;
    logic        w_last_pix;
    logic        w_final;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req) w_next = S_RUN;
            S_RUN:   if (r_cnt == 12'd4094) w_next = S_DRAIN;
            S_DRAIN: if (w_final) w_next = S_DONE;
            S_DONE:  if (!req) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Index 0 is issued on the start edge itself, straight from init_pos.
    assign w_start     = (r_state == S_IDLE) && req;
    assign w_issue     = w_start || (r_state == S_RUN);
    assign w_issue_idx = w_start ? 12'd0 : (r_cnt + 12'd1);
    assign w_pos       = w_start ? init_pos : r_init;

    // Displacement code c maps to c-2; fields wrap modulo 64.
    assign w_addr_w = w_pos[11:6] + {4'd0, w_issue_idx[11:10]} + {2'd0, w_issue_idx[7:4]} - 6'd2;
    assign w_addr_h = w_pos[5:0]  + {4'd0, w_issue_idx[9:8]}   + {2'd0, w_issue_idx[3:0]} - 6'd2;

    assign w_ad        = (pel_sw >= pel_tb) ? (pel_sw - pel_tb) : (pel_tb - pel_sw);
    assign w_sad       = r_acc + {8'd0, w_ad};
    assign w_better    = (w_sad < r_best);
    assign w_cand_diff = r_b_cnt[11:8] ^ 4'b1010;
    assign w_last_pix  = r_b_v && (r_b_cnt[7:0] == 8'hFF);
    assign w_final     = r_b_v && (r_b_cnt == 12'hFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init      <= '0;
            r_cnt       <= '0;
            r_a_v       <= 1'b0;
            r_b_v       <= 1'b0;
            r_b_cnt     <= '0;
            r_acc       <= '0;
            r_best      <= '0;
            r_best_diff <= '0;
            r_min_sad   <= '0;
            r_min_diff  <= '0;
            r_ack       <= 1'b0;
            r_addr_sw   <= '0;
            r_addr_tb   <= '0;
        end else begin
            // Two-stage tag pipeline tracks which index the returning pixels belong to.
            r_a_v   <= w_issue;
            r_b_v   <= r_a_v;
            r_b_cnt <= r_cnt;

            if (w_issue) begin
                r_cnt     <= w_issue_idx;
                r_addr_sw <= {w_addr_w, w_addr_h};
                r_addr_tb <= w_issue_idx[7:0];
            end

            if (w_start) begin
                r_init      <= init_pos;
                r_acc       <= '0;
                r_best      <= 16'hFFFF;
                r_best_diff <= '0;
            end else if (r_b_v) begin
                if (w_last_pix) begin
                    r_acc <= '0;
                    if (w_better) begin
                        r_best      <= w_sad;
                        r_best_diff <= w_cand_diff;
                    end
                end else begin
                    r_acc <= w_sad;
                end
            end

            if (w_final) begin
                r_min_sad  <= w_better ? w_sad : r_best;
                r_min_diff <= w_better ? w_cand_diff : r_best_diff;
                r_ack      <= 1'b1;
            end else if ((r_state == S_DONE) && !req) begin
                r_ack <= 1'b0;
            end
        end
    end

    assign min_sad  = r_min_sad;
    assign min_diff = r_min_diff;
    assign ack      = r_ack;
    assign addr_sw  = r_addr_sw;
    assign addr_tb  = r_addr_tb;

endmodule

// File: tb/tb_me_integer_core.sv
// Directed bench for me_integer_core with behavioural SW/TB memories and a
// scoreboard queue of expected {min_sad, min_diff} results.
module tb_me_integer_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [11:0] init_pos;
    logic [15:0] min_sad;
    logic [3:0]  min_diff;
    logic        ack;
    logic [7:0]  pel_sw;
    logic [7:0]  pel_tb;
    logic [11:0] addr_sw;
    logic [7:0]  addr_tb;

    logic [7:0]  sw_mem [4096];
    logic [7:0]  tb_mem [256];
    logic [19:0] exp_q [$];
    logic [19:0] last_exp;
    logic [11:0] addr_hist [4];
    logic [7:0]  addr_tb_hist [4];
    logic        prev_ack;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    me_integer_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .init_pos (init_pos),
        .min_sad  (min_sad),
        .min_diff (min_diff),
        .ack      (ack),
        .pel_sw   (pel_sw),
        .pel_tb   (pel_tb),
        .addr_sw  (addr_sw),
        .addr_tb  (addr_tb)
    );

    // Single-cycle-latency synchronous memories.
    always @(posedge clk) begin
        pel_sw <= sw_mem[addr_sw];
        pel_tb <= tb_mem[addr_tb];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every rising ack pops one expected result.
    initial prev_ack = 1'b0;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ack === 1'b1 && prev_ack !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: unexpected result sad=%0d diff=%0d", min_sad, min_diff);
            end else begin
                check("result", {12'd0, min_sad, min_diff}, {12'd0, exp_q.pop_front()});
            end
        end
        prev_ack = ack;
    end

    task automatic fill(input logic [7:0] sw_val, input logic [7:0] tb_val);
        for (int i = 0; i < 4096; i++) sw_mem[i] = sw_val;
        for (int i = 0; i < 256; i++)  tb_mem[i] = tb_val;
    endtask

    task automatic run_search(input logic [11:0] pos, input logic [19:0] exp,
                              input int hold, input bit release_rst);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        init_pos = pos;
        req = 1'b1;
        exp_q.push_back(exp);
        while (n < 5000 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n <= 4) begin
                addr_hist[n-1]    = addr_sw;
                addr_tb_hist[n-1] = addr_tb;
            end
            if (n == 1) init_pos = ~pos;
            if (n == 2000) begin
                check("held_sad", {16'd0, min_sad}, {16'd0, last_exp[19:4]});
                check("held_diff", {28'd0, min_diff}, {28'd0, last_exp[3:0]});
            end
            if (ack) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack after %0d cycles required 4098", n);
        end else begin
            check("ack_latency", n, 4098);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_ack", {31'd0, ack}, 32'd1);
            check("hold_result", {12'd0, min_sad, min_diff}, {12'd0, exp});
        end
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ack_drop", {31'd0, ack}, 32'd0);
        last_exp = exp;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        req      = 1'b0;
        init_pos = '0;
        last_exp = '0;
        fill(8'd0, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_sad", {16'd0, min_sad}, 32'd0);
        check("rst_diff", {28'd0, min_diff}, 32'd0);
        check("rst_addr_sw", {20'd0, addr_sw}, 32'd0);
        check("rst_addr_tb", {24'd0, addr_tb}, 32'd0);
        rst_n = 1'b1;

        // Constant offset with wrap-around addressing from init_pos = 0.
        fill(8'd0, 8'd10);
        run_search(12'd0, {16'd2560, 4'b1010}, 10, 1'b0);
        check("wrap_first", {20'd0, addr_hist[0]}, {20'd0, 6'd62, 6'd62});
        check("wrap_second", {20'd0, addr_hist[1]}, {20'd0, 6'd62, 6'd63});
        check("wrap_h_zero", {20'd0, addr_hist[2]}, {20'd0, 6'd62, 6'd0});
        check("tb_third", {24'd0, addr_tb_hist[2]}, 32'd2);
        check("wrap_last", {20'd0, addr_sw}, {20'd0, 6'd16, 6'd16});
        check("tb_last", {24'd0, addr_tb}, 32'd255);
        // Re-raise: identical second search.
        run_search(12'd0, {16'd2560, 4'b1010}, 0, 1'b0);

        // Exact match at (w=23, h=42) from init (22, 44): displacement (+1, -2).
        for (int i = 0; i < 4096; i++) sw_mem[i] = 8'($urandom_range(0, 255));
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                tb_mem[x*16 + y] = sw_mem[((23 + x) % 64) * 64 + ((42 + y) % 64)];
        run_search({6'd22, 6'd44}, {16'd0, 4'b0110}, 2, 1'b0);

        // Maximum SAD.
        fill(8'd255, 8'd0);
        run_search(12'hA5C, {16'd65280, 4'b1010}, 0, 1'b0);

        // Asynchronous reset mid-search, then a fresh search with req held.
        @(negedge clk);
        init_pos = 12'h3C7;
        req = 1'b1;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ack", {31'd0, ack}, 32'd0);
        check("abort_sad", {16'd0, min_sad}, 32'd0);
        check("abort_diff", {28'd0, min_diff}, 32'd0);
        check("abort_addr_sw", {20'd0, addr_sw}, 32'd0);
        check("abort_addr_tb", {24'd0, addr_tb}, 32'd0);
        last_exp = '0;
        run_search(12'h3C7, {16'd65280, 4'b1010}, 0, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
